mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

MEM-stage load/store unit for the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs, runs a req/ack handshake with data memory, formats load data and store byte lanes, and stalls upstream while an access is outstanding. It also drives the MEM/WB-side registered outputs consumed by writeback.

## Interface
- MAX_WAIT, default 255: BUSY cycles without ack before timeout abort. Range 1..255.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_rd  in  5  destination register from EX/MEM
- mem_alu_result  in  32  ALU result; the byte address for loads and stores
- mem_store_data  in  32  rs2 data from EX/MEM
- mem_reg_write  in  1  register write enable from EX/MEM
- mem_output_select  in  2  writeback mux select, passed through
- mem_read  in  1  load request
- mem_write  in  1  store request; wins if asserted together with mem_read
- mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- lsu_stall  out  1  combinational; holds PC/IF/ID/EX/MEM registers while high
- dmem_req  out  1  registered bus request
- dmem_we  out  1  registered; 1 = store
- dmem_addr  out  32  registered word address {addr[31:2],2'b00}
- dmem_wdata  out  32  registered, lane-replicated store data
- dmem_be  out  4  registered byte enables
- dmem_ack  in  1  one-cycle completion strobe from memory
- dmem_rdata  in  32  read word; valid when dmem_ack=1
- wb_rd  out  5  registered destination register
- wb_reg_write  out  1  registered register write enable
- wb_output_select  out  2  registered writeback mux select
- wb_alu_result  out  32  registered ALU result
- wb_load_data  out  32  registered, extended load data
- wb_fault  out  1  registered one-cycle pulse: misaligned access or timeout

## Operation
- States: IDLE, BUSY.
- access = mem_read | mem_write. aligned = (byte) | (half & !addr[0]) | (word & addr[1:0]==0).
- IDLE, no access: at the next edge, WB registers load the mem_* fields; wb_load_data=0; wb_fault=0.
- IDLE, access, misaligned: no bus request. At the next edge, WB registers load a bubble (wb_reg_write=0, wb_rd=0, other fields 0) and wb_fault=1. lsu_stall=0.
- IDLE, access, aligned:
  - lsu_stall=1.
  - At the edge: latch rd, reg_write, output_select, alu_result, size, unsigned, addr[1:0]; set dmem_req=1 and load dmem_we/addr/wdata/be; clear wait counter; go to BUSY.
  - WB registers load a bubble.
- Store formatting: byte -> wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]. Half -> wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0]. Word -> wdata=d, be=4'b1111.
- Load formatting: byte lane selected by addr[1:0], half lane by addr[1]. Sign- or zero-extend per the latched unsigned flag. Word loads pass through unchanged.
- BUSY, dmem_ack=0, counter<MAX_WAIT-1:
  - lsu_stall=1; counter increments.
  - dmem_* outputs held stable.
  - WB registers load a bubble.
- BUSY, dmem_ack=1:
  - lsu_stall=0.
  - At the edge: WB registers load the latched fields; wb_load_data is the formatted dmem_rdata for loads and 0 for stores.
  - Store: wb_reg_write is forced to 0.
  - dmem_req=0; go to IDLE.
- BUSY, ack absent and counter==MAX_WAIT-1 (timeout):
  - lsu_stall=0.
  - At the edge: dmem_req=0; WB registers load a bubble with wb_fault=1; go to IDLE.
- dmem_ack received in IDLE is ignored.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be = 0; all wb_* = 0; counter = 0.
- Reset during BUSY: dmem_req drops at that edge and the access is abandoned. An ack arriving after reset is ignored.
- Non-memory instruction latency: 1 cycle to wb_*, no stall.
- Memory access: accept cycle with stall, then BUSY. dmem_req first rises in cycle 1. If ack arrives in cycle 1, wb_* is valid after the cycle-1 edge: 1 stall cycle total.
- Each cycle of ack delay adds one stall cycle. Timeout after MAX_WAIT BUSY cycles.
- dmem_req rises only from IDLE and falls only on ack, timeout, or reset. A new access is accepted no earlier than the cycle after the ack/timeout edge, giving one request per access.
- lsu_stall is combinational from state, mem_read/mem_write, mem_size, addr[1:0], dmem_ack and the counter. No path from dmem_rdata.

## Test plan
- Pass-through ADD (rd=5, alu=0x1234, reg_write=1, select=01) -> next cycle wb_rd=5, wb_alu_result=0x1234, wb_output_select=01; lsu_stall never high.
- LB, addr=0x103, unsigned=0, ack in the first BUSY cycle with rdata=0x80FF_0000 -> one stall cycle; dmem_addr=0x100; wb_load_data=0xFFFFFF80; wb_reg_write=1.
- SH, addr=0x202, data=0xABCD1234, ack after 3 BUSY cycles -> dmem_be=1100, dmem_wdata=0x12341234, dmem_we=1; 3 stall cycles; wb_reg_write=0.
- LW, addr=0x101 -> no dmem_req; next cycle wb_fault=1, wb_reg_write=0; lsu_stall=0.
- LHU, MAX_WAIT=4, ack never given -> stall for exactly 4 cycles; then dmem_req=0, wb_fault=1; next instruction accepted.
- Reset asserted during BUSY, then a late ack -> dmem_req=0 and all wb_*=0 after the reset edge; the late ack causes no WB update.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake, store lane formatting,
// load extraction/extension, upstream stall and registered MEM/WB outputs.
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             mem_rd,
  input  logic [31:0]            mem_alu_result,
  input  logic [31:0]            mem_store_data,
  input  logic                   mem_reg_write,
  input  logic [1:0]             mem_output_select,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [1:0]             mem_size,
  input  logic                   mem_unsigned,
  output logic                   lsu_stall,
  mem_stage_lsu_if.master        bus,
  output logic [4:0]             wb_rd,
  output logic                   wb_reg_write,
  output logic [1:0]             wb_output_select,
  output logic [31:0]            wb_alu_result,
  output logic [31:0]            wb_load_data,
  output logic                   wb_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;
  logic        rw_q, uns_q;
  logic [1:0]  sel_q, size_q, off_q;
  logic [31:0] alu_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q, wb_fault_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] wb_alu_q, wb_ld_q;

  logic        access, aligned, timeout;
  logic [1:0]  off;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    off      = mem_alu_result[1:0];
    access   = mem_read | mem_write;
    aligned  = 1'b0;
    st_wdata = mem_store_data;
    st_be    = 4'b1111;
    case (mem_size)
      2'b00: begin
        aligned  = 1'b1;
        st_wdata = {4{mem_store_data[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        aligned  = ~off[0];
        st_wdata = {2{mem_store_data[15:0]}};
        st_be    = 4'b0011 << off;
      end
      default: aligned = (off == 2'b00);
    endcase
    timeout = (cnt_q == LAST_WAIT);
    // Stall never looks at rdata, keeping the memory read path off the stall net.
    if (state_q == IDLE) lsu_stall = access & aligned;
    else                 lsu_stall = ~bus.dmem_ack & ~timeout;
  end

  always_comb begin
    ld_byte = '0;
    case (off_q)
      2'd0:    ld_byte = bus.dmem_rdata[7:0];
      2'd1:    ld_byte = bus.dmem_rdata[15:8];
      2'd2:    ld_byte = bus.dmem_rdata[23:16];
      default: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      uns_q      <= 1'b0;
      sel_q      <= '0;
      size_q     <= '0;
      off_q      <= '0;
      alu_q      <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_sel_q   <= '0;
      wb_alu_q   <= '0;
      wb_ld_q    <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      // Bubble by default; the branches below override when writeback carries data.
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_sel_q   <= '0;
      wb_alu_q   <= '0;
      wb_ld_q    <= '0;
      wb_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!access) begin
            wb_rd_q  <= mem_rd;
            wb_rw_q  <= mem_reg_write;
            wb_sel_q <= mem_output_select;
            wb_alu_q <= mem_alu_result;
          end else if (!aligned) begin
            wb_fault_q <= 1'b1;
          end else begin
            rd_q    <= mem_rd;
            rw_q    <= mem_reg_write;
            sel_q   <= mem_output_select;
            alu_q   <= mem_alu_result;
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            off_q   <= off;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            addr_q  <= {mem_alu_result[31:2], 2'b00};
            wdata_q <= st_wdata;
            be_q    <= st_be;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.dmem_ack) begin
            wb_rd_q  <= rd_q;
            wb_rw_q  <= rw_q & ~we_q;
            wb_sel_q <= sel_q;
            wb_alu_q <= alu_q;
            wb_ld_q  <= we_q ? '0 : ld_data;
            req_q    <= 1'b0;
            state_q  <= IDLE;
          end else if (timeout) begin
            wb_fault_q <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_be    = be_q;

  assign wb_rd            = wb_rd_q;
  assign wb_reg_write     = wb_rw_q;
  assign wb_output_select = wb_sel_q;
  assign wb_alu_result    = wb_alu_q;
  assign wb_load_data     = wb_ld_q;
  assign wb_fault         = wb_fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases then random instructions
// against a transaction-level reference model.
module tb_mem_stage_lsu;
  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result, mem_store_data;
  logic        mem_reg_write, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_output_select, mem_size;
  logic        lsu_stall;
  logic [4:0]  wb_rd;
  logic        wb_reg_write, wb_fault;
  logic [1:0]  wb_output_select;
  logic [31:0] wb_alu_result, wb_load_data;

  int checks = 0;
  int failures = 0;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_reg_write(mem_reg_write), .mem_output_select(mem_output_select),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .lsu_stall(lsu_stall), .bus(bus),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_output_select(wb_output_select),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] ld, input logic flt);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(rw));
    check({tag, ".wb_sel"}, 32'(wb_output_select), 32'(sel));
    check({tag, ".wb_alu"}, wb_alu_result, alu);
    check({tag, ".wb_load"}, wb_load_data, ld);
    check({tag, ".wb_fault"}, 32'(wb_fault), 32'(flt));
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // ackd: BUSY cycle (1-based) in which ack is given; > MW means never.
  task automatic run_instr(input string tag, input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] sd, input logic rw, input logic [1:0] sel,
                           input logic rdq, input logic wrq, input logic [1:0] sz, input logic uns,
                           input int unsigned ackd, input logic [31:0] rdata, input logic idle_ack);
    int unsigned nbytes;
    logic acc, al;
    logic [31:0] exp_wd, exp_addr;
    logic [3:0] exp_be;
    nbytes   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    acc      = rdq | wrq;
    al       = (alu % nbytes) == 0;
    exp_addr = alu - (alu % 4);
    exp_be   = 4'(((1 << nbytes) - 1) << (alu % 4));
    exp_wd   = (nbytes == 1) ? 32'(sd[7:0]) * 32'h01010101 :
               (nbytes == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;

    mem_rd = rd; mem_alu_result = alu; mem_store_data = sd; mem_reg_write = rw;
    mem_output_select = sel; mem_read = rdq; mem_write = wrq; mem_size = sz; mem_unsigned = uns;
    bus.dmem_ack = idle_ack; bus.dmem_rdata = $urandom;
    #1;
    check({tag, ".stall0"}, 32'(lsu_stall), 32'(acc && al));
    tick();
    bus.dmem_ack = 1'b0;
    if (!acc) begin
      check_wb(tag, rd, rw, sel, alu, 32'd0, 1'b0);
      check({tag, ".req"}, 32'(bus.dmem_req), 32'd0);
    end else if (!al) begin
      check_wb(tag, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
      check({tag, ".req"}, 32'(bus.dmem_req), 32'd0);
    end else begin
      check({tag, ".req"}, 32'(bus.dmem_req), 32'd1);
      check({tag, ".we"}, 32'(bus.dmem_we), 32'(wrq));
      check({tag, ".addr"}, bus.dmem_addr, exp_addr);
      if (wrq) begin
        check({tag, ".wdata"}, bus.dmem_wdata, exp_wd);
        check({tag, ".be"}, 32'(bus.dmem_be), 32'(exp_be));
      end
      check({tag, ".bubble_rw"}, 32'(wb_reg_write), 32'd0);
      check({tag, ".bubble_flt"}, 32'(wb_fault), 32'd0);
      for (int unsigned c = 1; c <= MW; c++) begin
        bus.dmem_ack   = (c == ackd);
        bus.dmem_rdata = (c == ackd) ? rdata : $urandom;
        // Upstream fields are scrambled while busy: only the latched copy may be used.
        mem_rd = 5'($urandom); mem_alu_result = $urandom; mem_store_data = $urandom;
        mem_reg_write = 1'($urandom); mem_output_select = 2'($urandom);
        mem_read = 1'($urandom); mem_write = 1'($urandom); mem_size = 2'($urandom);
        mem_unsigned = 1'($urandom);
        #1;
        check({tag, ".stall_busy"}, 32'(lsu_stall), 32'(c != ackd && c < MW));
        tick();
        bus.dmem_ack = 1'b0;
        if (c == ackd) begin
          check_wb({tag, ".done"}, rd, rw && !wrq, sel, alu,
                   wrq ? 32'd0 : model_load(rdata, alu[1:0], sz, uns), 1'b0);
          check({tag, ".req_drop"}, 32'(bus.dmem_req), 32'd0);
          break;
        end else if (c == MW) begin
          check_wb({tag, ".tmo"}, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
          check({tag, ".req_tmo"}, 32'(bus.dmem_req), 32'd0);
        end else begin
          check({tag, ".req_hold"}, 32'(bus.dmem_req), 32'd1);
          check({tag, ".addr_hold"}, bus.dmem_addr, exp_addr);
          check({tag, ".wait_rw"}, 32'(wb_reg_write), 32'd0);
          check({tag, ".wait_flt"}, 32'(wb_fault), 32'd0);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_rd = '0; mem_alu_result = '0; mem_store_data = '0; mem_reg_write = 1'b0;
    mem_output_select = '0; mem_read = 1'b0; mem_write = 1'b0; mem_size = '0; mem_unsigned = 1'b0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    tick();
    tick();
    check("rst.req", 32'(bus.dmem_req), 32'd0);
    check("rst.we", 32'(bus.dmem_we), 32'd0);
    check("rst.addr", bus.dmem_addr, 32'd0);
    check("rst.wdata", bus.dmem_wdata, 32'd0);
    check("rst.be", 32'(bus.dmem_be), 32'd0);
    check_wb("rst", 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;

    run_instr("add", 5'd5, 32'h1234, 32'h0, 1'b1, 2'b01, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0, 1'b0);
    run_instr("lb", 5'd7, 32'h103, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd0, 1'b0, 1, 32'h80FF_0000, 1'b0);
    run_instr("sh", 5'd9, 32'h202, 32'hABCD1234, 1'b1, 2'b00, 1'b0, 1'b1, 2'd1, 1'b0, 3, 32'h0, 1'b0);
    run_instr("lw_mis", 5'd3, 32'h101, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2, 1'b0, 1, 32'h0, 1'b0);
    run_instr("lhu_tmo", 5'd4, 32'h302, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd1, 1'b1, MW + 1, 32'h0, 1'b0);
    run_instr("after_tmo", 5'd6, 32'h55, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0, 1'b1);
    run_instr("lw_sz3", 5'd8, 32'h404, 32'h0, 1'b1, 2'b10, 1'b1, 1'b0, 2'd3, 1'b0, 2, 32'hDEADBEEF, 1'b0);

    // Reset while BUSY, followed by a late ack.
    mem_rd = 5'd12; mem_alu_result = 32'h40; mem_reg_write = 1'b1; mem_output_select = 2'b10;
    mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
    tick();
    check("rbusy.req", 32'(bus.dmem_req), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rbusy.req_rst", 32'(bus.dmem_req), 32'd0);
    check_wb("rbusy", 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    mem_rd = '0; mem_alu_result = '0; mem_reg_write = 1'b0; mem_output_select = '0;
    mem_read = 1'b0; mem_write = 1'b0;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
    #1;
    check("late.stall", 32'(lsu_stall), 32'd0);
    tick();
    bus.dmem_ack = 1'b0;
    check("late.req", 32'(bus.dmem_req), 32'd0);
    check_wb("late", 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int unsigned kind;
      logic rdq, wrq;
      kind = $urandom_range(0, 3);
      rdq  = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      wrq  = (kind == 2) || (kind == 3);
      run_instr("rnd", 5'($urandom), $urandom, $urandom, 1'($urandom), 2'($urandom),
                rdq, wrq, 2'($urandom), 1'($urandom), $urandom_range(1, MW + 1),
                $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
